// File: rtl/axi4_sram_slave.sv
// AXI4 responder in front of a word-addressed on-chip SRAM.
// One transaction at a time; INCR/FIXED bursts; configurable read/write latency.
module axi4_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [3:0]  S_AXI_AWID,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic [3:0]  S_AXI_BID,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  input  logic [3:0]  S_AXI_ARID,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic [3:0]  S_AXI_RID,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, WR_RESP
  } state_t;

  state_t state, state_n;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] cur_addr, nxt_addr, cur_off, nxt_off;
  logic [31:0] rdata;
  logic [7:0]  len, cnt, lat;
  logic [2:0]  size;
  logic [1:0]  burst, bacc, rresp, bresp;
  logic [1:0]  cur_resp, nxt_resp;
  logic [3:0]  id, rid, bid;
  logic        rvalid, rlast, bvalid, bad_attr;
  logic        aw_hs, ar_hs, w_hs, r_hs, w_last, w_mis;
  logic [AW-1:0] cur_idx, nxt_idx;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign nxt_addr = (burst == 2'b00) ? cur_addr
                  : {cur_addr[31:2], 2'b00} + 32'd4;
  assign cur_off  = cur_addr - BASE_ADDR;
  assign nxt_off  = nxt_addr - BASE_ADDR;
  assign cur_idx  = cur_off[AW+1:2];
  assign nxt_idx  = nxt_off[AW+1:2];
  assign bad_attr = (size > 3'd2) || burst[1];
  assign cur_resp = (cur_off >= SPAN) ? 2'b11 : bad_attr ? 2'b10 : 2'b00;
  assign nxt_resp = (nxt_off >= SPAN) ? 2'b11 : bad_attr ? 2'b10 : 2'b00;

  assign S_AXI_AWREADY = (state == IDLE) && !reset;
  assign S_AXI_ARREADY = (state == IDLE) && !reset && !S_AXI_AWVALID;
  assign S_AXI_WREADY  = (state == WR_DATA) && !reset;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RID     = rid;
  assign S_AXI_RLAST   = rlast;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_BID     = bid;

  assign aw_hs  = S_AXI_AWREADY && S_AXI_AWVALID;
  assign ar_hs  = S_AXI_ARREADY && S_AXI_ARVALID;
  assign w_hs   = S_AXI_WREADY && S_AXI_WVALID;
  assign r_hs   = (state == RD_DATA) && S_AXI_RREADY;
  assign w_last = (cnt == len);
  assign w_mis  = S_AXI_WLAST != w_last;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (aw_hs) state_n = WR_DATA;
               else if (ar_hs) state_n = RD_WAIT;
      RD_WAIT: if (lat == 8'd1) state_n = RD_DATA;
      RD_DATA: if (r_hs && rlast) state_n = IDLE;
      WR_DATA: if (w_hs && w_last) state_n = WR_WAIT;
      WR_WAIT: if (lat == 8'd1) state_n = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr <= '0;
      len      <= '0;
      size     <= '0;
      burst    <= '0;
      id       <= '0;
      cnt      <= '0;
      lat      <= '0;
      bacc     <= '0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rdata    <= '0;
      rresp    <= '0;
      rid      <= '0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      bid      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            cur_addr <= S_AXI_AWADDR;
            len      <= S_AXI_AWLEN;
            size     <= S_AXI_AWSIZE;
            burst    <= S_AXI_AWBURST;
            id       <= S_AXI_AWID;
            cnt      <= '0;
            bacc     <= 2'b00;
          end else if (ar_hs) begin
            cur_addr <= S_AXI_ARADDR;
            len      <= S_AXI_ARLEN;
            size     <= S_AXI_ARSIZE;
            burst    <= S_AXI_ARBURST;
            id       <= S_AXI_ARID;
            cnt      <= '0;
            lat      <= 8'(RD_LATENCY);
          end
        end
        RD_WAIT: begin
          lat <= lat - 8'd1;
          if (lat == 8'd1) begin
            rvalid <= 1'b1;
            rdata  <= (cur_resp == 2'b00) ? mem[cur_idx] : '0;
            rresp  <= cur_resp;
            rid    <= id;
            rlast  <= (len == 8'd0);
          end
        end
        RD_DATA: begin
          // next beat is loaded on the same edge so held RREADY streams
          if (S_AXI_RREADY) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              cnt      <= cnt + 8'd1;
              cur_addr <= nxt_addr;
              rdata    <= (nxt_resp == 2'b00) ? mem[nxt_idx] : '0;
              rresp    <= nxt_resp;
              rlast    <= (cnt + 8'd1 == len);
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            bacc <= worst(worst(bacc, cur_resp), w_mis ? 2'b10 : 2'b00);
            if (w_last) begin
              lat <= 8'(WR_LATENCY);
            end else begin
              cnt      <= cnt + 8'd1;
              cur_addr <= nxt_addr;
            end
          end
        end
        WR_WAIT: begin
          lat <= lat - 8'd1;
          if (lat == 8'd1) begin
            bvalid <= 1'b1;
            bresp  <= bacc;
            bid    <= id;
          end
        end
        WR_RESP: if (S_AXI_BREADY) bvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && cur_resp == 2'b00) begin
      for (int i = 0; i < 4; i++) begin
        if (S_AXI_WSTRB[i]) mem[cur_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: vector table plus burst, arbitration
// and mid-burst reset sequences.
module tb_axi4_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [31:0] rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [3:0]  awid = '0, arid = '0, wstrb = '0, bid, rid;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0;
  logic        arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;

  int vecs = 0;
  int miss = 0;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam int LIM = 50;

  always #5 clk = ~clk;

  axi4_sram_slave dut (
    .clock(clk), .reset(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BID(bid), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RID(rid),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct {
    logic        wr;
    logic        badl;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    vecs++;
    miss++;
    $display("FAIL %s: timeout after %0d cycles", name, LIM);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] bt,
                          input logic [2:0] sz, input logic [31:0] d,
                          input logic [3:0] st, input logic badl,
                          output logic [1:0] resp, output logic [3:0] bid_o,
                          output int lat);
    int n;
    resp = 'x; bid_o = 'x; lat = -1;
    awaddr = a; awid = id; awlen = len; awburst = bt; awsize = sz;
    awvalid = 1;
    n = 0;
    #1;
    while (!awready && n < LIM) begin @(negedge clk); n++; #1; end
    @(negedge clk);
    awvalid = 0;
    if (n >= LIM) begin tmo("aw_ready"); return; end
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d + 32'(i); wstrb = st;
      wlast = badl ? 1'b0 : (i == int'(len));
      wvalid = 1;
      n = 0;
      #1;
      while (!wready && n < LIM) begin @(negedge clk); n++; #1; end
      @(negedge clk);
      if (n >= LIM) begin wvalid = 0; tmo("w_ready"); return; end
    end
    wvalid = 0; wlast = 0;
    n = 0;
    while (!bvalid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) begin tmo("b_valid"); return; end
    lat = n; resp = bresp; bid_o = bid;
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] bt,
                         input logic [2:0] sz,
                         output logic [31:0] d0, output logic [1:0] r0,
                         output logic [3:0] id0, output int lat,
                         output int beats, output logic last_ok);
    int n;
    logic done;
    d0 = 'x; r0 = 'x; id0 = 'x; lat = -1; beats = 0; last_ok = 0;
    araddr = a; arid = id; arlen = len; arburst = bt; arsize = sz;
    arvalid = 1;
    n = 0;
    #1;
    while (!arready && n < LIM) begin @(negedge clk); n++; #1; end
    @(negedge clk);
    arvalid = 0;
    if (n >= LIM) begin tmo("ar_ready"); return; end
    n = 0;
    while (!rvalid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) begin tmo("r_valid"); return; end
    lat = n;
    rready = 1;
    last_ok = 1;
    done = 0;
    while (rvalid && !done && beats < 300) begin
      if (beats == 0) begin d0 = rdata; r0 = rresp; id0 = rid; end
      if (rlast !== (beats == int'(len))) last_ok = 0;
      done = rlast;
      beats++;
      @(negedge clk);
    end
    rready = 0;
  endtask

  vec_t tbl [22];
  logic [31:0] pexp [5];
  logic        plast [5];
  logic        pready [5];

  initial begin
    logic [31:0] d0;
    logic [1:0]  r0;
    logic [3:0]  i0;
    int          lat, beats, n;
    logic        lok, blocked;

    tbl[0]  = '{1'b1, 1'b0, 32'h8000_0010, 4'h3, 8'd0, INCR,  3'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h8000_0010, 4'h5, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h8000_0020, 4'h1, 8'd0, INCR,  3'd2, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h8000_0021, 4'h2, 8'd0, INCR,  3'd0, 32'h0000_AA00, 4'h2, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h8000_0020, 4'h7, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'h1122_AA44};
    tbl[5]  = '{1'b0, 1'b0, 32'h8000_0023, 4'h0, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'h1122_AA44};
    tbl[6]  = '{1'b1, 1'b0, 32'h8000_0014, 4'h4, 8'd0, INCR,  3'd2, 32'h0102_0304, 4'hF, 2'b00, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h8000_0010, 4'h9, 8'd1, WRAP,  3'd2, 32'h5555_5555, 4'hF, 2'b10, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h8000_0010, 4'hA, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    tbl[9]  = '{1'b0, 1'b0, 32'h8000_0014, 4'hB, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'h0102_0304};
    tbl[10] = '{1'b0, 1'b0, 32'h9000_0000, 4'hC, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b11, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h7FFF_FFFC, 4'hD, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b11, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h8000_0FFC, 4'hE, 8'd0, INCR,  3'd2, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h8000_0FFC, 4'hF, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    tbl[14] = '{1'b0, 1'b0, 32'h8000_1000, 4'h1, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b11, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h8000_0010, 4'h2, 8'd0, INCR,  3'd3, 32'h0,         4'h0, 2'b10, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h9000_0000, 4'h3, 8'd0, INCR,  3'd2, 32'h1234_5678, 4'hF, 2'b11, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 32'h8000_0030, 4'h4, 8'd2, FIXED, 3'd2, 32'h0000_00A0, 4'hF, 2'b00, 32'h0};
    tbl[18] = '{1'b0, 1'b0, 32'h8000_0030, 4'h5, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'h0000_00A2};
    tbl[19] = '{1'b1, 1'b1, 32'h8000_0050, 4'h6, 8'd0, INCR,  3'd2, 32'h5A5A_5A5A, 4'hF, 2'b10, 32'h0};
    tbl[20] = '{1'b0, 1'b0, 32'h8000_0050, 4'h7, 8'd0, INCR,  3'd2, 32'h0,         4'h0, 2'b00, 32'h5A5A_5A5A};
    tbl[21] = '{1'b1, 1'b0, 32'h8000_0000, 4'h8, 8'd3, INCR,  3'd2, 32'h0000_0100, 4'hF, 2'b00, 32'h0};

    pexp   = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h103};
    plast  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pready = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({awready, arready, wready, bvalid, rvalid, rlast}), 64'h0);
    chk("reset_data", {rdata, rresp, bresp, rid, bid, 20'h0}, 64'h0);
    rst = 0;
    #1;
    chk("idle_ready", 64'({awready, arready}), 64'h3);
    @(negedge clk);

    for (int k = 0; k < 22; k++) begin
      if (tbl[k].wr) begin
        do_write(tbl[k].addr, tbl[k].id, tbl[k].len, tbl[k].burst,
                 tbl[k].size, tbl[k].data, tbl[k].strb, tbl[k].badl,
                 r0, i0, lat);
        chk($sformatf("vec%0d_wr{resp,id,lat}", k),
            64'({r0, i0, 8'(lat)}),
            64'({tbl[k].exp_resp, tbl[k].id, 8'd1}));
      end else begin
        do_read(tbl[k].addr, tbl[k].id, tbl[k].len, tbl[k].burst,
                tbl[k].size, d0, r0, i0, lat, beats, lok);
        chk($sformatf("vec%0d_rd{resp,id,data,lat,beats,last}", k),
            64'({r0, i0, d0, 8'(lat), 8'(beats), lok}),
            64'({tbl[k].exp_resp, tbl[k].id, tbl[k].exp_data, 8'd2,
                 8'(int'(tbl[k].len) + 1), 1'b1}));
      end
    end

    // INCR burst with a one-cycle RREADY stall on beat 1
    araddr = 32'h8000_0000; arid = 4'hA; arlen = 8'd3; arburst = INCR;
    arsize = 3'd2; arvalid = 1;
    n = 0;
    #1;
    while (!arready && n < LIM) begin @(negedge clk); n++; #1; end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) tmo("burst_rvalid");
    else begin
      for (int k = 0; k < 5; k++) begin
        rready = pready[k];
        chk($sformatf("burst_obs%0d{valid,last,id,data}", k),
            64'({rvalid, rlast, rid, rdata}),
            64'({1'b1, plast[k], 4'hA, pexp[k]}));
        @(negedge clk);
      end
      rready = 0;
      chk("burst_end_rvalid", 64'(rvalid), 64'h0);
    end

    // simultaneous AW and AR: write wins, read waits for B
    awaddr = 32'h8000_0040; awid = 4'h6; awlen = 8'd0; awburst = INCR;
    awsize = 3'd2; awvalid = 1;
    araddr = 32'h8000_0040; arid = 4'h8; arlen = 8'd0; arburst = INCR;
    arsize = 3'd2; arvalid = 1;
    #1;
    chk("arb_ready{aw,ar}", 64'({awready, arready}), 64'h2);
    @(negedge clk);
    awvalid = 0;
    wdata = 32'h0000_0077; wstrb = 4'hF; wlast = 1; wvalid = 1;
    blocked = 1;
    n = 0;
    #1;
    while (!wready && n < LIM) begin
      if (arready) blocked = 0;
      @(negedge clk); n++; #1;
    end
    @(negedge clk);
    wvalid = 0; wlast = 0;
    n = 0;
    while (!bvalid && n < LIM) begin
      if (arready) blocked = 0;
      @(negedge clk); n++;
    end
    if (n >= LIM) tmo("arb_bvalid");
    else begin
      chk("arb_b{resp,id,ar_blocked}", 64'({bresp, bid, blocked, arready}),
          64'({2'b00, 4'h6, 1'b1, 1'b0}));
      bready = 1;
      @(negedge clk);
      bready = 0;
      #1;
      chk("arb_ar_after_b", 64'(arready), 64'h1);
      @(negedge clk);
      arvalid = 0;
      n = 0;
      while (!rvalid && n < LIM) begin @(negedge clk); n++; end
      if (n >= LIM) tmo("arb_rvalid");
      else begin
        chk("arb_read{resp,id,last,data,lat}",
            64'({rresp, rid, rlast, rdata, 8'(n)}),
            64'({2'b00, 4'h8, 1'b1, 32'h0000_0077, 8'd2}));
        rready = 1;
        @(negedge clk);
        rready = 0;
      end
    end

    // reset while a read beat is stalled
    araddr = 32'h8000_0020; arid = 4'h2; arlen = 8'd1; arburst = INCR;
    arsize = 3'd2; arvalid = 1;
    n = 0;
    #1;
    while (!arready && n < LIM) begin @(negedge clk); n++; #1; end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) tmo("rst_rvalid");
    else begin
      @(negedge clk);
      chk("stall_hold{valid,last,data}", 64'({rvalid, rlast, rdata}),
          64'({1'b1, 1'b0, 32'h1122_AA44}));
      rst = 1;
      @(negedge clk);
      chk("midrst{rvalid,rlast,bvalid}", 64'({rvalid, rlast, bvalid}), 64'h0);
      rst = 0;
      #1;
      chk("midrst_idle", 64'({awready, arready}), 64'h3);
      @(negedge clk);
      do_read(32'h8000_0020, 4'h9, 8'd0, INCR, 3'd2, d0, r0, i0, lat, beats, lok);
      chk("post_rst_read{resp,id,data}", 64'({r0, i0, d0}),
          64'({2'b00, 4'h9, 32'h1122_AA44}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
